branch_resolve_unit: RTL and testbench

//  Write-side companion of the branch target buffer (BTB); the BTB read port stays in IF.
//  - Carries each IF prediction (BTB hit, predicted target, BHT direction) through the ID and EX pipeline registers.
//  - In EX, compares the prediction with the actual branch outcome.
//  - Drives the BTB write port and the 2-bit BHT update.
//  - Raises a redirect/flush on a mispredict and keeps branch statistics.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/branch_resolve_unit_if.sv | 41 ++++
 rtl/bht_table.sv | 34 +++
 rtl/branch_resolve_unit.sv | 92 +++++++++
 tb/tb_branch_resolve_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch resolve unit: BHT counter states and the
// per-stage prediction record carried from IF down to EX.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = WNT;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_info_t;

    // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bht_state_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bht_state_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the IF/ID/EX pipeline and the branch resolve unit:
// IF lookup, pipeline-register control, EX outcome, BTB write and redirect.
interface branch_resolve_unit_if #(parameter int CNT_WIDTH = 32);

    logic [31:0]          PCF;
    logic                 ReadPredictF;
    logic [31:0]          PCReadPredictF;
    logic                 PredictTakenF;
    logic                 StallD;
    logic                 FlushD;
    logic                 StallE;
    logic                 FlushE;
    logic [31:0]          PCE;
    logic                 BranchE;
    logic                 BrTakenE;
    logic [31:0]          BrTargetE;
    logic                 BTBWrite;
    logic [31:0]          PCWrite;
    logic [31:0]          PCWritePredict;
    logic                 Redirect;
    logic [31:0]          RedirectPC;
    logic [CNT_WIDTH-1:0] BranchCnt;
    logic [CNT_WIDTH-1:0] MispredCnt;

    modport master (
        output PCF, ReadPredictF, PCReadPredictF,
        output StallD, FlushD, StallE, FlushE,
        output PCE, BranchE, BrTakenE, BrTargetE,
        input  PredictTakenF, BTBWrite, PCWrite, PCWritePredict,
        input  Redirect, RedirectPC, BranchCnt, MispredCnt
    );

    modport slave (
        input  PCF, ReadPredictF, PCReadPredictF,
        input  StallD, FlushD, StallE, FlushE,
        input  PCE, BranchE, BrTakenE, BrTargetE,
        output PredictTakenF, BTBWrite, PCWrite, PCWritePredict,
        output Redirect, RedirectPC, BranchCnt, MispredCnt
    );

endinterface

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters with an
// asynchronous read port and a synchronous read-modify-write update port.
module bht_table
    import bp_pkg::*;
#(
    parameter int ADDR_LEN = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] rd_idx,
    output bht_state_t          rd_state,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int DEPTH = 1 << ADDR_LEN;

    bht_state_t cnt_q [DEPTH];

    // Read sees the pre-edge contents, so a same-index update in this cycle is not visible yet.
    assign rd_state = cnt_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_RESET_STATE;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Write-side companion of the BTB: carries IF predictions to EX, resolves them,
// updates BTB and BHT, raises redirects and counts branches and mispredicts.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int BHT_ADDR_LEN = 12,
    parameter int CNT_WIDTH    = 32
) (
    input logic                 clk,
    input logic                 rst,
    branch_resolve_unit_if.slave bus
);

    bht_state_t           rd_state;
    logic                 predict_taken_f;
    pred_info_t           pred_d;
    pred_info_t           pred_e;
    logic                 upd;
    logic                 resolve;
    logic                 actual_taken;
    logic                 tgt_differs;
    logic                 mis_dir;
    logic                 mis_tgt;
    logic                 redirect;
    logic                 btb_write;
    logic [31:0]          redirect_pc;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    bht_table #(.ADDR_LEN(BHT_ADDR_LEN)) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.PCF[BHT_ADDR_LEN+1:2]),
        .rd_state (rd_state),
        .wr_en    (resolve),
        .wr_idx   (bus.PCE[BHT_ADDR_LEN+1:2]),
        .wr_taken (bus.BrTakenE)
    );

    assign predict_taken_f = bus.ReadPredictF && rd_state[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_d <= '0;
            pred_e <= '0;
        end else begin
            if (bus.FlushD) begin
                pred_d <= '0;
            end else if (!bus.StallD) begin
                pred_d <= '{taken: predict_taken_f, target: bus.PCReadPredictF};
            end
            if (bus.FlushE) begin
                pred_e <= '0;
            end else if (!bus.StallE) begin
                pred_e <= pred_d;
            end
        end
    end

    // A stalled EX instruction is resolved only in its final, unstalled cycle.
    always_comb begin
        upd          = !rst && !bus.StallE;
        resolve      = upd && bus.BranchE;
        actual_taken = bus.BranchE && bus.BrTakenE;
        tgt_differs  = pred_e.target != bus.BrTargetE;
        mis_dir      = bus.BranchE ? (pred_e.taken != bus.BrTakenE) : pred_e.taken;
        mis_tgt      = actual_taken && pred_e.taken && tgt_differs;
        redirect     = upd && (mis_dir || mis_tgt);
        btb_write    = upd && actual_taken && (!pred_e.taken || tgt_differs);
        redirect_pc  = actual_taken ? bus.BrTargetE : bus.PCE + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve) branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            if (redirect) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.PredictTakenF  = predict_taken_f;
    assign bus.BTBWrite       = btb_write;
    assign bus.PCWrite        = bus.PCE;
    assign bus.PCWritePredict = bus.BrTargetE;
    assign bus.Redirect       = redirect;
    assign bus.RedirectPC     = redirect_pc;
    assign bus.BranchCnt      = branch_cnt;
    assign bus.MispredCnt     = mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// random traffic, all checked against a table/queue-level reference model.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    branch_resolve_unit_if #(.CNT_WIDTH(32)) bus ();

    branch_resolve_unit #(.BHT_ADDR_LEN(12), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // driven input values, also the model's view of the inputs
    bit        i_rst, i_rp, i_sd, i_fd, i_se, i_fe, i_br, i_brt;
    bit [31:0] i_pcf, i_prt, i_pce, i_tgt;

    // reference model: one counter value (0..3) per BHT index, and the prediction
    // record sitting in each of the D and E pipeline registers
    int unsigned m_bht [4096];
    bit          md_t, me_t;
    bit [31:0]   md_tgt, me_tgt;
    bit [31:0]   m_bcnt, m_mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit exp_pf();
        return i_rp && (m_bht[i_pcf[13:2]] >= 2);
    endfunction

    function automatic bit exp_active();
        return !i_rst && !i_se;
    endfunction

    function automatic bit exp_redirect();
        bit wrong_dir, wrong_tgt;
        if (i_br) wrong_dir = (me_t != i_brt);
        else      wrong_dir = me_t;
        wrong_tgt = i_br && i_brt && me_t && (me_tgt != i_tgt);
        return exp_active() && (wrong_dir || wrong_tgt);
    endfunction

    function automatic bit exp_btbw();
        bit btb_had_it;
        btb_had_it = me_t && (me_tgt == i_tgt);
        return exp_active() && i_br && i_brt && !btb_had_it;
    endfunction

    task automatic check_model();
        bit [31:0] rpc;
        rpc = (i_br && i_brt) ? i_tgt : i_pce + 32'd4;
        chk("pred_taken_f", 32'(bus.PredictTakenF), 32'(exp_pf()));
        chk("redirect",     32'(bus.Redirect),      32'(exp_redirect()));
        chk("redirect_pc",  bus.RedirectPC,         rpc);
        chk("btb_write",    32'(bus.BTBWrite),      32'(exp_btbw()));
        chk("pc_write",     bus.PCWrite,            i_pce);
        chk("pc_write_pred", bus.PCWritePredict,    i_tgt);
        chk("branch_cnt",   bus.BranchCnt,          m_bcnt);
        chk("mispred_cnt",  bus.MispredCnt,         m_mcnt);
    endtask

    task automatic model_update();
        bit        pf;
        bit        mis;
        int unsigned idx;
        bit        old_d_t;
        bit [31:0] old_d_tgt;
        if (i_rst) begin
            foreach (m_bht[k]) m_bht[k] = 1;
            md_t = 0; md_tgt = 0; me_t = 0; me_tgt = 0;
            m_bcnt = 0; m_mcnt = 0;
        end else begin
            pf  = exp_pf();
            mis = exp_redirect();
            if (exp_active() && i_br) begin
                idx = i_pce[13:2];
                if (i_brt) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else       m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                m_bcnt = m_bcnt + 1;
            end
            if (mis) m_mcnt = m_mcnt + 1;
            old_d_t   = md_t;
            old_d_tgt = md_tgt;
            if (i_fe) begin
                me_t = 0; me_tgt = 0;
            end else if (!i_se) begin
                me_t = old_d_t; me_tgt = old_d_tgt;
            end
            if (i_fd) begin
                md_t = 0; md_tgt = 0;
            end else if (!i_sd) begin
                md_t = pf; md_tgt = i_prt;
            end
        end
    endtask

    task automatic apply(input bit r, input bit [31:0] pcf, input bit rp, input bit [31:0] prt,
                         input bit sd, input bit fd, input bit se, input bit fe,
                         input bit [31:0] pce, input bit br, input bit brt, input bit [31:0] tgt,
                         input bit do_chk);
        @(negedge clk);
        i_rst = r; i_pcf = pcf; i_rp = rp; i_prt = prt;
        i_sd = sd; i_fd = fd; i_se = se; i_fe = fe;
        i_pce = pce; i_br = br; i_brt = brt; i_tgt = tgt;
        rst = r;
        bus.PCF = pcf; bus.ReadPredictF = rp; bus.PCReadPredictF = prt;
        bus.StallD = sd; bus.FlushD = fd; bus.StallE = se; bus.FlushE = fe;
        bus.PCE = pce; bus.BranchE = br; bus.BrTakenE = brt; bus.BrTargetE = tgt;
        #1;
        if (do_chk) check_model();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
    endtask

    task automatic bubble();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        tick();
    endtask

    task automatic predict(input bit [31:0] pcf, input bit [31:0] prt, input string tag);
        apply(0, pcf, 1, prt, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        chk(tag, 32'(bus.PredictTakenF), 32'd1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit [31:0] b0, m0;
        bit [31:0] tsel [3];
        tsel[0] = 32'h200; tsel[1] = 32'h300; tsel[2] = 32'h400;

        // reset state
        apply(1, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        tick();
        apply(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1);
        chk("t1_pf_in_rst", 32'(bus.PredictTakenF), 32'd0);
        chk("t1_redir_in_rst", 32'(bus.Redirect), 32'd0);
        tick();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        chk("t1_bcnt", bus.BranchCnt, 32'd0);
        chk("t1_mcnt", bus.MispredCnt, 32'd0);
        tick();

        // cold taken branch
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1);
        chk("t2_redirect", 32'(bus.Redirect), 32'd1);
        chk("t2_rpc", bus.RedirectPC, 32'h200);
        chk("t2_btbw", 32'(bus.BTBWrite), 32'd1);
        chk("t2_pcw", bus.PCWrite, 32'h100);
        chk("t2_pcwp", bus.PCWritePredict, 32'h200);
        tick();
        predict(32'h100, 32'h200, "t2_bht_now_taken");

        // two more taken resolutions saturate the counter
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1); tick();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1); tick();
        predict(32'h100, 32'h200, "t3_pf");
        bubble();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1);
        chk("t3_redirect", 32'(bus.Redirect), 32'd0);
        chk("t3_btbw", 32'(bus.BTBWrite), 32'd0);
        tick();

        // wrong target, then wrong direction
        predict(32'h100, 32'h200, "t4_pf_a");
        bubble();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 1, 32'h300, 1);
        chk("t4_tgt_redirect", 32'(bus.Redirect), 32'd1);
        chk("t4_tgt_rpc", bus.RedirectPC, 32'h300);
        chk("t4_tgt_btbw", 32'(bus.BTBWrite), 32'd1);
        chk("t4_tgt_pcwp", bus.PCWritePredict, 32'h300);
        tick();
        predict(32'h100, 32'h200, "t4_pf_b");
        bubble();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 0, 32'h200, 1);
        chk("t4_dir_redirect", 32'(bus.Redirect), 32'd1);
        chk("t4_dir_rpc", bus.RedirectPC, 32'h104);
        chk("t4_dir_btbw", 32'(bus.BTBWrite), 32'd0);
        tick();

        // mispredict held in EX by a stall
        bubble();
        b0 = m_bcnt; m0 = m_mcnt;
        for (int c = 0; c < 3; c++) begin
            apply(0, 32'h0, 0, 32'h0, 1, 0, 1, 0, 32'h100, 1, 1, 32'h200, 1);
            chk("t5_stall_redirect", 32'(bus.Redirect), 32'd0);
            chk("t5_stall_btbw", 32'(bus.BTBWrite), 32'd0);
            chk("t5_stall_bcnt", bus.BranchCnt, b0);
            tick();
        end
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1);
        chk("t5_release_redirect", 32'(bus.Redirect), 32'd1);
        tick();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        chk("t5_bcnt_step", bus.BranchCnt, b0 + 32'd1);
        chk("t5_mcnt_step", bus.MispredCnt, m0 + 32'd1);
        tick();

        // flush beats stall in E; then a BTB alias on a non-branch
        predict(32'h100, 32'h200, "t6_pf_a");
        predict(32'h100, 32'h200, "t6_pf_b");
        apply(0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 32'h500, 0, 0, 32'h0, 1);
        chk("t6_stalled_alias", 32'(bus.Redirect), 32'd0);
        tick();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h500, 0, 0, 32'h0, 1);
        chk("t6_bubble_redirect", 32'(bus.Redirect), 32'd0);
        tick();
        apply(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h500, 0, 0, 32'h0, 1);
        chk("t6_alias_redirect", 32'(bus.Redirect), 32'd1);
        chk("t6_alias_rpc", bus.RedirectPC, 32'h504);
        tick();

        // random traffic over a small PC set so BHT indices collide often
        for (int n = 0; n < 3000; n++) begin
            bit [31:0] pcf, pce;
            pcf = 32'h100 + ($urandom % 8) * 4;
            pce = (($urandom % 32) == 0) ? 32'hFFFF_FFFC : 32'h100 + ($urandom % 8) * 4;
            apply(($urandom % 97) == 0, pcf, ($urandom % 3) != 0, tsel[$urandom % 3],
                  ($urandom % 6) == 0, ($urandom % 9) == 0,
                  ($urandom % 5) == 0, ($urandom % 9) == 0,
                  pce, ($urandom % 4) != 0, ($urandom % 2) == 0, tsel[$urandom % 3], 1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
